tictactoe_host: RTL and testbench
=================================

Name: tictactoe_host

Overview:
Host-side driver for the tictactoe game core: the opposite end of the core's move interface. It buffers human moves in a small FIFO and issues each one to the core's xoroin/rowin/colin inputs as a one-cycle strobe. It checks the core's err/win response, waits for the AI reply when AI mode is enabled, and reports game state to the board/UI logic.

Parameters:
DEPTH, 4, move FIFO entries (power of 2, ≥2)
TIMEOUT, 64, max cycles to wait for an AI move before flagging timeout
CNTW, 4, width of the rejected-move counter (saturating)

Ports:
ph1  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
new_game  in  1  pulse: flush FIFO, clear status, latch ai_mode and human
ai_mode  in  1  AI opponent enable, latched on new_game
human  in  2  human symbol, latched on new_game: 01=X, 10=O
mv_valid  in  1  move FIFO write request
mv_ready  out  1  FIFO not full
mv_row, mv_col  in  2 each  move coordinate, 0..2; value 3 is illegal
xoroin  out  2  to core; 00 except during the ISSUE cycle
rowin, colin  out  2 each  to core; valid when xoroin≠00, otherwise 00
ai_en  out  1  to core; equals the latched ai_mode
err  in  1  from core: move rejected
xoroout, rowout, colout  in  2 each  from core: AI move
win  in  2  from core: 00 none, 01 X, 10 O, 11 draw
game_over  out  1  game ended (win, draw or timeout)
result  out  2  final win code; 00 if the game ended by timeout
ai_row, ai_col  out  2 each  last AI move received
ai_valid  out  1  one-cycle pulse when an AI move is captured
rej_cnt  out  CNTW  count of rejected human moves, saturating
timeout  out  1  sticky: AI failed to answer

Behaviour:
- Reset (async, reset=0) and new_game: FIFO emptied, state=IDLE, all outputs 0. Latched human=01, ai_mode=0 after reset.
- FIFO: write when mv_valid&&mv_ready; mv_ready=!full. A write while full is dropped. Simultaneous write and pop is allowed at any occupancy except full.
- FSM: IDLE, ISSUE, CHECK, WAIT_AI, DONE.
- IDLE: if FIFO non-empty, pop the head and go to ISSUE. A head entry with row or col =3 is popped and discarded: rej_cnt++, stay in IDLE, never sent to the core.
- ISSUE, exactly 1 cycle: xoroin=human, rowin/colin=popped move. Next state CHECK.
- CHECK samples err/win one cycle after the strobe:
  - win≠00: DONE, result=win.
  - else err=1: rej_cnt++, IDLE (human moves again).
  - else ai_mode=1: WAIT_AI, timer cleared.
  - else: IDLE.
- WAIT_AI, each cycle:
  - win≠00 → DONE, result=win.
  - else xoroout = opponent symbol (~human & 2'b11) → capture ai_row/ai_col, pulse ai_valid, go to IDLE.
  - else timer++; timer==TIMEOUT-1 → timeout=1, DONE, result=00.
  - win takes priority over a move arriving in the same cycle.
- DONE: game_over=1. FIFO writes are still accepted, but nothing issues until new_game.
- new_game has priority over all events and acts like reset, except ai_mode/human are latched from the inputs.
- rej_cnt saturates at 2^CNTW-1.
- Latency: FIFO write to ISSUE ≥2 cycles when IDLE and empty (write → IDLE pop → ISSUE).

Decomposition:
- Shared package tictactoe_pkg: xoro_t encodings (EMPTY=00, X=01, O=10), win_t (NONE, XWIN, OWIN, DRAW), host state enum, coordinate type.
- Sub-module: move_fifo (DEPTH-parameterized synchronous FIFO, 4-bit entries, full/empty flags). The FSM stays in tictactoe_host.

Test Plan:
- Reset: hold reset=0 mid-game → all outputs 0, mv_ready=1, xoroin=00 immediately (asynchronous).
- Single move, ai_mode=0, human=X: write (1,2) → one cycle later xoroin=01, rowin=1, colin=2 for exactly 1 cycle. Core err=0, win=00 → back to IDLE.
- AI reply, ai_mode=1: issue (0,0). Core drives xoroout=10, rowout=1, colout=1 three cycles later → ai_valid pulses once, ai_row=1, ai_col=1.
- Rejection: err=1 in CHECK → rej_cnt 0→1, next queued move issued. Queued (3,0) → rej_cnt++ with no strobe; force 20 rejections with CNTW=4 → rej_cnt stays 15.
- Win/draw/timeout:
  - win=01 in CHECK → game_over=1, result=01; a further FIFO write produces no strobe until new_game.
  - No AI answer → timeout=1 after exactly 64 WAIT_AI cycles, result=00.
- FIFO full: 4 writes with no pops → mv_ready=0; 5th write dropped. Verify issue order matches write order.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types for the tictactoe host: cell symbols, win codes, host FSM
// states and the packed move record stored in the move FIFO.
package tictactoe_pkg;

  localparam int unsigned MOVE_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } xoro_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    XWIN = 2'b01,
    OWIN = 2'b10,
    DRAW = 2'b11
  } win_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    WAIT_AI,
    DONE
  } host_state_t;

  typedef logic [1:0] coord_t;

  typedef struct packed {
    coord_t row;
    coord_t col;
  } move_t;

  function automatic logic [1:0] opponent(input logic [1:0] sym);
    return ~sym & 2'b11;
  endfunction

endpackage

// File: rtl/tictactoe_host_fifo.sv
// move_fifo: DEPTH-entry synchronous FIFO of packed moves.
// Ports: ph1 clock, reset async active-low, clear sync flush,
//        wr/wdata write side (ignored while full), rd/rdata pop side
//        (rdata shows the head combinationally), full/empty flags.
module move_fifo
  import tictactoe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr,
  input  logic [MOVE_W-1:0] wdata,
  input  logic              rd,
  output logic [MOVE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [MOVE_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_wr;
  logic              do_rd;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge ph1) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tictactoe_host.sv
// tictactoe_host: host side of the tictactoe core move interface.
// Buffers human moves, strobes each legal one to the core for one cycle,
// evaluates err/win, waits for the AI reply when enabled, reports status.
// Ports: ph1/reset (async active-low); new_game/ai_mode/human game setup;
//        mv_valid/mv_ready/mv_row/mv_col move input; xoroin/rowin/colin/ai_en
//        to core; err/xoroout/rowout/colout/win from core; game_over/result/
//        ai_row/ai_col/ai_valid/rej_cnt/timeout status.
module tictactoe_host
  import tictactoe_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNTW    = 4
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            new_game,
  input  logic            ai_mode,
  input  logic [1:0]      human,
  input  logic            mv_valid,
  output logic            mv_ready,
  input  logic [1:0]      mv_row,
  input  logic [1:0]      mv_col,
  output logic [1:0]      xoroin,
  output logic [1:0]      rowin,
  output logic [1:0]      colin,
  output logic            ai_en,
  input  logic            err,
  input  logic [1:0]      xoroout,
  input  logic [1:0]      rowout,
  input  logic [1:0]      colout,
  input  logic [1:0]      win,
  output logic            game_over,
  output logic [1:0]      result,
  output logic [1:0]      ai_row,
  output logic [1:0]      ai_col,
  output logic            ai_valid,
  output logic [CNTW-1:0] rej_cnt,
  output logic            timeout
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  host_state_t   state;
  xoro_t         human_l;
  logic          ai_l;
  logic [TW-1:0] timer;
  move_t         head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          head_bad;
  logic [CNTW-1:0] rej_next;

  // The head is consumed in IDLE whether it is legal or not.
  assign pop      = (state == IDLE) && !empty && !new_game;
  assign head_bad = (head.row == 2'd3) || (head.col == 2'd3);
  assign rej_next = (rej_cnt == '1) ? rej_cnt : rej_cnt + 1'b1;
  assign mv_ready = !full;
  assign ai_en    = ai_l;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ph1   (ph1),
    .reset (reset),
    .clear (new_game),
    .wr    (mv_valid),
    .wdata ({mv_row, mv_col}),
    .rd    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      human_l   <= X;
      ai_l      <= 1'b0;
      timer     <= '0;
      xoroin    <= '0;
      rowin     <= '0;
      colin     <= '0;
      game_over <= 1'b0;
      result    <= '0;
      ai_row    <= '0;
      ai_col    <= '0;
      ai_valid  <= 1'b0;
      rej_cnt   <= '0;
      timeout   <= 1'b0;
    end else if (new_game) begin
      state     <= IDLE;
      human_l   <= xoro_t'(human);
      ai_l      <= ai_mode;
      timer     <= '0;
      xoroin    <= '0;
      rowin     <= '0;
      colin     <= '0;
      game_over <= 1'b0;
      result    <= '0;
      ai_row    <= '0;
      ai_col    <= '0;
      ai_valid  <= 1'b0;
      rej_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      ai_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_bad) begin
              rej_cnt <= rej_next;
            end else begin
              xoroin <= human_l;
              rowin  <= head.row;
              colin  <= head.col;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          xoroin <= '0;
          rowin  <= '0;
          colin  <= '0;
          state  <= CHECK;
        end
        CHECK: begin
          if (win != NONE) begin
            game_over <= 1'b1;
            result    <= win;
            state     <= DONE;
          end else if (err) begin
            rej_cnt <= rej_next;
            state   <= IDLE;
          end else if (ai_l) begin
            timer <= '0;
            state <= WAIT_AI;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_AI: begin
          if (win != NONE) begin
            game_over <= 1'b1;
            result    <= win;
            state     <= DONE;
          end else if (xoroout == opponent(human_l)) begin
            ai_row   <= rowout;
            ai_col   <= colout;
            ai_valid <= 1'b1;
            state    <= IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout   <= 1'b1;
            game_over <= 1'b1;
            result    <= '0;
            state     <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tictactoe_host.sv
module tb_tictactoe_host;

  logic       ph1 = 1'b0;
  logic       reset;
  logic       new_game;
  logic       ai_mode;
  logic [1:0] human;
  logic       mv_valid;
  logic       mv_ready;
  logic [1:0] mv_row;
  logic [1:0] mv_col;
  logic [1:0] xoroin;
  logic [1:0] rowin;
  logic [1:0] colin;
  logic       ai_en;
  logic       err = 1'b0;
  logic [1:0] xoroout;
  logic [1:0] rowout;
  logic [1:0] colout;
  logic [1:0] win = 2'b00;
  logic       game_over;
  logic [1:0] result;
  logic [1:0] ai_row;
  logic [1:0] ai_col;
  logic       ai_valid;
  logic [3:0] rej_cnt;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] exp_q[$];
  logic [3:0] ai_q[$];
  logic [5:0] exp_s;
  logic [3:0] ai_e;
  logic       resp_err = 1'b0;
  logic [1:0] resp_win = 2'b00;
  logic       pend_err = 1'b0;
  logic [1:0] pend_win = 2'b00;
  logic       strobe_d = 1'b0;
  logic [1:0] tb_human = 2'b01;
  int         ai_pulses = 0;

  tictactoe_host #(.DEPTH(4), .TIMEOUT(64), .CNTW(4)) dut (
    .ph1       (ph1),
    .reset     (reset),
    .new_game  (new_game),
    .ai_mode   (ai_mode),
    .human     (human),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .mv_row    (mv_row),
    .mv_col    (mv_col),
    .xoroin    (xoroin),
    .rowin     (rowin),
    .colin     (colin),
    .ai_en     (ai_en),
    .err       (err),
    .xoroout   (xoroout),
    .rowout    (rowout),
    .colout    (colout),
    .win       (win),
    .game_over (game_over),
    .result    (result),
    .ai_row    (ai_row),
    .ai_col    (ai_col),
    .ai_valid  (ai_valid),
    .rej_cnt   (rej_cnt),
    .timeout   (timeout)
  );

  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor plus core response model: err/win answer the strobe
  // in the following (CHECK) cycle using the knobs captured at the strobe.
  always @(negedge ph1) begin
    if (reset) begin
      err = 1'b0;
      win = 2'b00;
      if (strobe_d) begin
        err = pend_err;
        win = pend_win;
      end
      if (xoroin != 2'b00) begin
        check("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_s = exp_q.pop_front();
          check("strobe_move", {xoroin, rowin, colin}, exp_s);
        end
        pend_err = resp_err;
        pend_win = resp_win;
      end else begin
        check("idle_coords", {rowin, colin}, 0);
      end
      strobe_d = (xoroin != 2'b00);
      if (ai_valid) begin
        ai_pulses++;
        check("ai_expected", ai_q.size() != 0, 1);
        if (ai_q.size() != 0) begin
          ai_e = ai_q.pop_front();
          check("ai_move", {ai_row, ai_col}, ai_e);
        end
      end
    end else begin
      err = 1'b0;
      win = 2'b00;
      strobe_d = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ph1);
  endtask

  task automatic write_move(input logic [1:0] r, input logic [1:0] c, input bit issue);
    mv_valid = 1'b1;
    mv_row = r;
    mv_col = c;
    if (issue) exp_q.push_back({tb_human, r, c});
    @(negedge ph1);
    mv_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, output int waited);
    waited = 0;
    do begin
      @(negedge ph1);
      waited++;
    end while (xoroin == 2'b00 && waited < 100);
    check(tag, xoroin != 2'b00, 1);
  endtask

  task automatic start_game(input logic ai, input logic [1:0] h);
    check("queue_drained", exp_q.size(), 0);
    new_game = 1'b1;
    ai_mode = ai;
    human = h;
    @(negedge ph1);
    new_game = 1'b0;
    tb_human = h;
  endtask

  task automatic ai_reply(input logic [1:0] r, input logic [1:0] c);
    xoroout = ~tb_human & 2'b11;
    rowout = r;
    colout = c;
    ai_q.push_back({r, c});
    @(negedge ph1);
    xoroout = 2'b00;
    rowout = 2'b00;
    colout = 2'b00;
  endtask

  initial begin
    int w;
    int exp_rej;
    logic [1:0] fr [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic [1:0] fc [4] = '{2'd1, 2'd2, 2'd0, 2'd2};
    logic [1:0] ar [4] = '{2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] ac [4] = '{2'd0, 2'd2, 2'd2, 2'd1};

    reset = 1'b0; new_game = 1'b0; ai_mode = 1'b0; human = 2'b01;
    mv_valid = 1'b0; mv_row = 2'b00; mv_col = 2'b00;
    xoroout = 2'b00; rowout = 2'b00; colout = 2'b00;

    // Reset state
    tick(3);
    check("rst_ready", mv_ready, 1);
    check("rst_xoroin", xoroin, 0);
    check("rst_over", game_over, 0);
    check("rst_rej", rej_cnt, 0);
    check("rst_ai_en", ai_en, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result", result, 0);
    reset = 1'b1;
    tick(2);

    // Single move, no AI
    start_game(1'b0, 2'b01);
    write_move(2'd1, 2'd2, 1);
    wait_strobe("single_seen", w);
    check("issue_latency", w, 1);
    tick(3);
    check("single_over", game_over, 0);
    check("single_rej", rej_cnt, 0);

    // AI mode, FIFO fill while waiting for the AI, issue order
    start_game(1'b1, 2'b01);
    check("ai_en", ai_en, 1);
    write_move(2'd0, 2'd0, 1);
    wait_strobe("ai_first_seen", w);
    tick(3);
    for (int i = 0; i < 4; i++) write_move(fr[i], fc[i], 1);
    check("full_ready", mv_ready, 0);
    write_move(2'd2, 2'd1, 0);
    check("still_full", mv_ready, 0);
    ai_reply(2'd1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      wait_strobe("fifo_seen", w);
      tick(3);
      ai_reply(ar[i], ac[i]);
    end
    tick(4);
    check("drained_ready", mv_ready, 1);
    check("ai_pulses", ai_pulses, 5);
    check("ai_over", game_over, 0);

    // Rejection by core, then next queued move
    start_game(1'b0, 2'b01);
    resp_err = 1'b1;
    write_move(2'd0, 2'd0, 1);
    wait_strobe("rej_seen", w);
    #1 resp_err = 1'b0;
    write_move(2'd2, 2'd1, 1);
    wait_strobe("rej_next_seen", w);
    check("rej_next_lat", w, 2);
    check("rej_after_err", rej_cnt, 1);
    tick(3);
    check("rej_hold", rej_cnt, 1);

    // Illegal coordinates and saturation
    exp_rej = 1;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) write_move(2'd3, 2'(i % 3), 0);
      else            write_move(2'(i % 3), 2'd3, 0);
      tick(1);
      exp_rej = (exp_rej == 15) ? 15 : exp_rej + 1;
      check("rej_sat", rej_cnt, exp_rej);
    end

    // Win in CHECK, writes while DONE do not issue
    start_game(1'b0, 2'b01);
    resp_win = 2'b01;
    write_move(2'd2, 2'd0, 1);
    wait_strobe("win_seen", w);
    #1 resp_win = 2'b00;
    tick(2);
    check("win_over", game_over, 1);
    check("win_result", result, 1);
    write_move(2'd1, 2'd1, 0);
    tick(5);
    check("done_hold", game_over, 1);
    check("done_ready", mv_ready, 1);

    // New game as O flushes the pending move; draw ends it
    start_game(1'b0, 2'b10);
    check("ng_over", game_over, 0);
    check("ng_result", result, 0);
    resp_win = 2'b11;
    write_move(2'd0, 2'd2, 1);
    wait_strobe("draw_seen", w);
    #1 resp_win = 2'b00;
    tick(2);
    check("draw_over", game_over, 1);
    check("draw_result", result, 3);

    // AI timeout
    start_game(1'b1, 2'b01);
    write_move(2'd1, 2'd0, 1);
    wait_strobe("to_seen", w);
    tick(65);
    check("to_early", timeout, 0);
    check("to_early_over", game_over, 0);
    tick(1);
    check("to_flag", timeout, 1);
    check("to_over", game_over, 1);
    check("to_result", result, 0);

    // Asynchronous reset from DONE with a pending move
    write_move(2'd0, 2'd1, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_over", game_over, 0);
    check("arst_timeout", timeout, 0);
    check("arst_ai_en", ai_en, 0);
    check("arst_ready", mv_ready, 1);
    @(negedge ph1);
    reset = 1'b1;
    tick(4);

    // Asynchronous reset during a strobe
    start_game(1'b0, 2'b01);
    write_move(2'd1, 2'd2, 1);
    wait_strobe("rst_strobe_seen", w);
    #2 reset = 1'b0;
    #1;
    check("arst_xoroin", xoroin, 0);
    check("arst_coords", {rowin, colin}, 0);
    @(negedge ph1);
    reset = 1'b1;
    tick(4);

    check("exp_q_left", exp_q.size(), 0);
    check("ai_q_left", ai_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
